alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Parametrised iterative multiply/divide unit with architectural HI/LO registers, placed beside the single-cycle integer ALU in the EX stage of the MIPS pipeline. It executes mult, multu, div, divu, mthi and mtlo under a start/busy/done handshake. The hazard unit stalls on `busy` and reads `hi`/`lo` directly for mfhi/mflo. It can be widened or narrowed via `WIDTH`, and it supports abort on pipeline flush, which the single-cycle ALU has no need for.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4 and even.
- `CNTW`, $clog2(WIDTH)+1: iteration counter width (derived; do not override).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  operation request; sampled only when `busy`=0.
- `op`  in  3  operation code (from shared package).
- `A`  in  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source).
- `B`  in  WIDTH  rt operand (divisor / multiplier).
- `flush`  in  1  abort the in-flight operation.
- `busy`  out  1  operation in progress; the pipeline stalls on it.
- `done`  out  1  one-cycle pulse when `hi`/`lo` hold the new result.
- `hi`  out  WIDTH  HI register (high product / remainder).
- `lo`  out  WIDTH  LO register (low product / quotient).

## Operation
- **Op codes:** MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5. Codes 6 and 7 are no-ops: `start` is ignored.
- **FSM states:**
  - IDLE → CALC on `start` with op 0–3.
  - CALC → FIX after WIDTH iterations.
  - FIX → IDLE.
  - MTHI/MTLO never leave IDLE.
- **Operand capture:** on accept, latch the operand signs (signed ops only) and the magnitudes |A|, |B| as WIDTH-bit unsigned values. The most-negative value maps to 2^(WIDTH-1) unsigned.
- **CALC, multiply:** radix-2 shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- **CALC, divide:** restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- **FIX, sign correction:**
  - Product is negated if sign(A)^sign(B).
  - Quotient is negated if sign(A)^sign(B).
  - Remainder takes sign(A).
  - Results wrap modulo 2^WIDTH; there is no overflow flag.
- **FIX, divide by zero** (B=0, signed or unsigned): lo = all ones, hi = A unmodified.
- **Most-negative ÷ −1:** lo = 2^(WIDTH-1) pattern, hi = 0.
- **Writeback:** `hi`/`lo` are written only at the FIX→IDLE edge; the partial state is internal.
- **MTHI/MTLO:** written at the accept edge; `done` pulses the next cycle; `busy` stays 0.
- **Flush:**
  - In CALC or FIX: go to IDLE at the next edge, leave hi/lo unchanged, no `done`.
  - In IDLE: the same-cycle `start` is ignored (flush wins).
- **`start` while busy:** ignored; there is no queueing.
- **Reset:** state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset overrides flush and start, including mid-operation.

## Timing
- Cycle 0: `start` sampled high with busy=0.
- mult/div:
  - `busy`=1 in cycles 1..WIDTH+1.
  - Cycle WIDTH+2: busy=0, done=1, and hi/lo show the result.
  - Total latency is WIDTH+2 cycles (34 at WIDTH=32).
- A `start` sampled in the `done` cycle is accepted, giving back-to-back throughput of one operation per WIDTH+2 cycles.
- mthi/mtlo: hi/lo updated and done=1 in cycle 1.
- `busy` is a registered state decode; no combinational path from `start` to `busy`.
- `hi`, `lo` and `done` are registered.

## Structure
- `muldiv_pkg` holds:
  - the op code localparams;
  - the state enum (IDLE, CALC, FIX);
  - a `neg` helper function (two's complement, WIDTH-generic via parameterised width).
- Sub-module `muldiv_step`: combinational single-iteration datapath. It takes the accumulator/remainder, operand and mode, and produces the next accumulator/remainder plus the quotient bit.
- The top level owns the FSM, counter, sign latches, HI/LO and handshake.

## Test plan
- **Signed and unsigned multiply** (WIDTH=32): A=0xFFFFFFFF, B=2.
  - MULT → hi=0xFFFFFFFF, lo=0xFFFFFFFE, done in cycle 34.
  - MULTU → hi=0x00000001, lo=0xFFFFFFFE.
- **Signed and unsigned divide:** DIV A=−7 (0xFFFFFFF9), B=2.
  - DIV → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU A=7, B=2 → lo=3, hi=1.
- **Corner cases:**
  - DIVU A=7, B=0 → lo=0xFFFFFFFF, hi=7.
  - DIV A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- **Abort paths:**
  - MTHI 0x1234 then MTLO 0x5678, then MULT 3×4 with flush in cycle 10 → hi=0x1234, lo=0x5678, no done, busy=0 by cycle 11.
  - Repeat with reset in cycle 10 → hi=lo=0.
- **Handshake:**
  - DIVU 100/7 with a new MULTU 5×6 asserted in the done cycle → first lo=14, hi=2; second lo=30, hi=0, with done exactly 34 cycles later.
  - `start` pulses during busy are ignored.
- **WIDTH=8 build:** MULT 0x80×0x80 → hi=0x40, lo=0x00, latency 10. DIV 0x80/0xFF → lo=0x80, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and a width-generic two's complement helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Callers zero-extend into this width and truncate the result back;
    // negation modulo 2^N is unaffected by the extra high bits.
    localparam int NEG_MAXW = 256;

    function automatic logic [NEG_MAXW-1:0] neg(input logic [NEG_MAXW-1:0] v);
        return ~v + NEG_MAXW'(1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: radix-2 shift-add for
// multiply, restoring subtract-and-shift for divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     rem,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic [WIDTH-1:0]     rem_next,
    output logic                 q_bit
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = operand[gi] & acc[0];
        end
    endgenerate

    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        rem_shift = {rem, acc[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, operand});
        acc_next  = acc;
        rem_next  = rem;
        q_bit     = 1'b0;
        if (is_div) begin
            // Dividend sits in acc's low half and is replaced bit by bit
            // with the quotient as it shifts out into the remainder.
            q_bit    = rem_ge;
            rem_next = rem_ge ? WIDTH'(rem_shift - {1'b0, operand}) : rem_shift[WIDTH-1:0];
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], rem_ge};
        end else begin
            // Multiplier sits in acc's low half; product grows in from the top.
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers,
// start/busy/done handshake and flush abort.
module alu_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;

    state_t             state_reg, state_next;
    logic [CNTW-1:0]    cnt_reg;
    logic [W2-1:0]      acc_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [WIDTH-1:0]   a_raw_reg;
    logic               sign_a_reg, sign_b_reg;
    logic               is_div_reg;
    logic               b_zero_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg;

    logic               accept, accept_md, accept_mt;
    logic               is_signed_op, is_div_in;
    logic               sign_a_in, sign_b_in;
    logic [WIDTH-1:0]   abs_a_in, abs_b_in;
    logic [W2-1:0]      step_acc;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [W2-1:0]      prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign accept    = (state_reg == IDLE) && start && !flush;
    assign accept_md = accept && ((op == OP_MULT) || (op == OP_MULTU) ||
                                  (op == OP_DIV)  || (op == OP_DIVU));
    assign accept_mt = accept && ((op == OP_MTHI) || (op == OP_MTLO));

    always_comb begin
        is_signed_op = (op == OP_MULT) || (op == OP_DIV);
        is_div_in    = (op == OP_DIV) || (op == OP_DIVU);
        sign_a_in    = is_signed_op & A[WIDTH-1];
        sign_b_in    = is_signed_op & B[WIDTH-1];
        // Most-negative input negates to itself, which is its correct magnitude unsigned.
        abs_a_in     = sign_a_in ? WIDTH'(neg(NEG_MAXW'(A))) : A;
        abs_b_in     = sign_b_in ? WIDTH'(neg(NEG_MAXW'(B))) : B;
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div   (is_div_reg),
        .acc      (acc_reg),
        .rem      (rem_reg),
        .operand  (opnd_reg),
        .acc_next (step_acc),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        prod   = (sign_a_reg ^ sign_b_reg) ? W2'(neg(NEG_MAXW'(acc_reg))) : acc_reg;
        fix_hi = prod[W2-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div_reg) begin
            if (b_zero_reg) begin
                fix_hi = a_raw_reg;
                fix_lo = '1;
            end else begin
                fix_lo = (sign_a_reg ^ sign_b_reg) ? WIDTH'(neg(NEG_MAXW'(acc_reg[WIDTH-1:0])))
                                                   : acc_reg[WIDTH-1:0];
                fix_hi = sign_a_reg ? WIDTH'(neg(NEG_MAXW'(rem_reg))) : rem_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept_md) state_next = CALC;
            CALC: begin
                if (flush)
                    state_next = IDLE;
                else if (cnt_reg == CNTW'(WIDTH - 1))
                    state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            rem_reg    <= '0;
            opnd_reg   <= '0;
            a_raw_reg  <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            is_div_reg <= 1'b0;
            b_zero_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept_md) begin
                cnt_reg    <= '0;
                rem_reg    <= '0;
                a_raw_reg  <= A;
                sign_a_reg <= sign_a_in;
                sign_b_reg <= sign_b_in;
                is_div_reg <= is_div_in;
                b_zero_reg <= (B == '0);
                acc_reg    <= {{WIDTH{1'b0}}, is_div_in ? abs_a_in : abs_b_in};
                opnd_reg   <= is_div_in ? abs_b_in : abs_a_in;
            end
            if (accept_mt) begin
                if (op == OP_MTHI)
                    hi_reg <= A;
                else
                    lo_reg <= A;
                done_reg <= 1'b1;
            end
            if ((state_reg == CALC) && !flush) begin
                acc_reg <= step_acc;
                rem_reg <= step_rem;
                cnt_reg <= cnt_reg + CNTW'(1);
            end
            if ((state_reg == FIX) && !flush) begin
                hi_reg   <= fix_hi;
                lo_reg   <= fix_lo;
                done_reg <= 1'b1;
            end
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32 and WIDTH=8.
module tb_alu_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, start, flush;
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    logic          start8, flush8;
    logic [2:0]    op8;
    logic [7:0]    a8, b8;
    logic          busy8, done8;
    logic [7:0]    hi8, lo8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (a),
        .B     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .op    (op8),
        .A     (a8),
        .B     (b8),
        .flush (flush8),
        .busy  (busy8),
        .done  (done8),
        .hi    (hi8),
        .lo    (lo8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in cycle 1 relative to the accept edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 1;
        busy_ok = 1'b1;
        while (!done && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
        int lat;
        bit bok;
        issue(o, x, y);
        wait_done(lat, bok);
        $display("%s op=%0d A=%h B=%h -> hi=%h lo=%h latency=%0d", tag, o, x, y, hi, lo, lat);
        check({tag, "_lat"}, 64'(lat), 64'(W + 2));
        check({tag, "_busy_during"}, 64'(bok), 64'd1);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
    endtask

    task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] eh, input logic [7:0] el);
        int lat;
        start8 = 1'b1;
        op8    = o;
        a8     = x;
        b8     = y;
        tick();
        start8 = 1'b0;
        lat    = 1;
        while (!done8 && lat < 100) begin
            tick();
            lat++;
        end
        $display("%s op=%0d A=%h B=%h -> hi=%h lo=%h latency=%0d", tag, o, x, y, hi8, lo8, lat);
        check({tag, "_lat"}, 64'(lat), 64'd10);
        check({tag, "_hi"}, 64'(hi8), 64'(eh));
        check({tag, "_lo"}, 64'(lo8), 64'(el));
    endtask

    initial begin
        int lat;
        bit bok;
        int done_cnt;

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
        start8 = 1'b0; flush8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
        tick();
        tick();
        $display("reset -> hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();

        run_op("mult_neg1x2",  3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        tick();
        check("done_pulse_width", 64'(done), 64'd0);
        run_op("multu_ffx2",   3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
        run_op("mult_maxxmin", 3'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
        run_op("div_m7_2",     3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_m2",     3'd2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu_7_2",     3'd3, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("divu_by0",     3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        run_op("div_by0",      3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("div_min_m1",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

        // mthi / mtlo complete in cycle 1 without raising busy
        issue(3'd4, 32'h1234, 32'd0);
        $display("mthi A=%h -> hi=%h done=%b busy=%b", 32'h1234, hi, done, busy);
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_done", 64'(done), 64'd1);
        check("mthi_busy", 64'(busy), 64'd0);
        issue(3'd5, 32'h5678, 32'd0);
        $display("mtlo A=%h -> lo=%h done=%b busy=%b", 32'h5678, lo, done, busy);
        check("mtlo_lo", 64'(lo), 64'h5678);
        check("mtlo_hi_kept", 64'(hi), 64'h1234);
        check("mtlo_done", 64'(done), 64'd1);
        tick();

        // unused op codes are ignored
        issue(3'd6, 32'hDEAD, 32'hBEEF);
        $display("op6 -> busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        check("op6_busy", 64'(busy), 64'd0);
        check("op6_done", 64'(done), 64'd0);
        check("op6_lo", 64'(lo), 64'h5678);

        // flush beats start in IDLE
        flush = 1'b1;
        issue(3'd0, 32'd3, 32'd4);
        flush = 1'b0;
        $display("start+flush -> busy=%b", busy);
        check("idle_flush_busy", 64'(busy), 64'd0);

        // flush mid-operation in cycle 10
        issue(3'd0, 32'd3, 32'd4);
        for (int c = 1; c < 10; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        $display("mult flushed -> busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hi", 64'(hi), 64'h1234);
        check("flush_lo", 64'(lo), 64'h5678);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) done_cnt++;
            tick();
        end
        check("flush_no_done", 64'(done_cnt), 64'd0);
        check("flush_hi_late", 64'(hi), 64'h1234);

        // reset mid-operation in cycle 10
        issue(3'd0, 32'd3, 32'd4);
        for (int c = 1; c < 10; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("mult reset -> busy=%b hi=%h lo=%h", busy, hi, lo);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        tick();

        // back-to-back: second start issued in the done cycle
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("multu_b2b",  3'd1, 32'd5, 32'd6, 32'd0, 32'd30);

        // start pulses while busy are ignored, not queued
        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        lat = 1;
        bok = 1'b1;
        while (!done && lat < 200) begin
            if (!busy) bok = 1'b0;
            if (lat == 5 || lat == 20) begin
                start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        $display("multu with busy pokes -> hi=%h lo=%h latency=%0d", hi, lo, lat);
        check("poke_lat", 64'(lat), 64'(W + 2));
        check("poke_busy", 64'(bok), 64'd1);
        check("poke_hi", 64'(hi), 64'd1);
        check("poke_lo", 64'(lo), 64'hFFFFFFFE);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("poke_not_queued", 64'(done_cnt), 64'd0);

        run8("w8_mult", 3'd0, 8'h80, 8'h80, 8'h40, 8'h00);
        run8("w8_div",  3'd2, 8'h80, 8'hFF, 8'h00, 8'h80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
